// File: rtl/panel_switch_bank.sv
// Front-panel switch bank: turns keyboard cursor actions into toggle, momentary
// and three-position AUX switch state, plus rate-limited command pulses.
module panel_switch_bank #(
   parameter int unsigned SWITCHES_ST_COUNT      = 18,
   parameter int unsigned SWITCHES_ST_AUX1_INDEX = 23,
   parameter int unsigned SWITCHES_ST_AUX2_INDEX = 24,
   parameter int unsigned LOCKOUT_CYCLES         = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [4:0]                   cursor_index,
   input  logic [1:0]                   cursor_action,
   output logic [SWITCHES_ST_COUNT-1:0] toggles,
   output logic [4:0]                   cmd_up_pos,
   output logic [4:0]                   cmd_dn_pos,
   output logic [4:0]                   cmd_up_pulse,
   output logic [4:0]                   cmd_dn_pulse,
   output logic [1:0]                   aux1_pos,
   output logic [1:0]                   aux2_pos
);

   localparam int unsigned MOM_COUNT = 5;
   localparam int unsigned LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
   localparam logic [4:0] AUX1_IDX = 5'(SWITCHES_ST_AUX1_INDEX);
   localparam logic [4:0] AUX2_IDX = 5'(SWITCHES_ST_AUX2_INDEX);

   typedef enum logic [1:0] {
      ACT_OFF  = 2'd0,
      ACT_UP   = 2'd1,
      ACT_DOWN = 2'd2,
      ACT_MOVE = 2'd3
   } act_e;

   logic [4:0]                   idx_q;
   act_e                         act_q, act_qq;
   logic [SWITCHES_ST_COUNT-1:0] tog_q, tog_d;
   logic [MOM_COUNT-1:0]         up_pos_q, up_pos_d;
   logic [MOM_COUNT-1:0]         dn_pos_q, dn_pos_d;
   logic [MOM_COUNT-1:0]         up_pulse_q, up_pulse_d;
   logic [MOM_COUNT-1:0]         dn_pulse_q, dn_pulse_d;
   logic [1:0]                   aux1_q, aux1_d;
   logic [1:0]                   aux2_q, aux2_d;
   logic [LOCK_W-1:0]            lock_q, lock_d;
   logic                         evt;

   // Only a change of action is an event; sliding the cursor alone is not.
   assign evt = (act_q != act_qq);

   always_comb begin
      tog_d      = tog_q;
      up_pos_d   = up_pos_q;
      dn_pos_d   = dn_pos_q;
      up_pulse_d = '0;
      dn_pulse_d = '0;
      aux1_d     = aux1_q;
      aux2_d     = aux2_q;
      lock_d     = (lock_q != '0) ? lock_q - LOCK_W'(1) : lock_q;

      if (evt) begin
         for (int unsigned i = 0; i < SWITCHES_ST_COUNT; i++) begin
            if (idx_q == 5'(i)) begin
               if (act_q == ACT_UP)
                  tog_d[i] = 1'b1;
               else if (act_q == ACT_OFF)
                  tog_d[i] = 1'b0;
            end
         end

         if (act_q == ACT_MOVE) begin
            up_pos_d = '0;
            dn_pos_d = '0;
         end

         // Positions always follow the press; the pulse is dropped during lockout.
         for (int unsigned i = 0; i < MOM_COUNT; i++) begin
            if (idx_q == 5'(SWITCHES_ST_COUNT + i)) begin
               unique case (act_q)
                  ACT_UP: begin
                     up_pos_d[i] = 1'b1;
                     dn_pos_d[i] = 1'b0;
                     if (lock_q == '0) begin
                        up_pulse_d[i] = 1'b1;
                        lock_d        = LOCK_LOAD;
                     end
                  end
                  ACT_DOWN: begin
                     up_pos_d[i] = 1'b0;
                     dn_pos_d[i] = 1'b1;
                     if (lock_q == '0) begin
                        dn_pulse_d[i] = 1'b1;
                        lock_d        = LOCK_LOAD;
                     end
                  end
                  default: begin
                     up_pos_d[i] = 1'b0;
                     dn_pos_d[i] = 1'b0;
                  end
               endcase
            end
         end

         if (act_q != ACT_MOVE) begin
            if (idx_q == AUX1_IDX)
               aux1_d = act_q;
            if (idx_q == AUX2_IDX)
               aux2_d = act_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q      <= '0;
         act_q      <= ACT_OFF;
         act_qq     <= ACT_OFF;
         tog_q      <= '0;
         up_pos_q   <= '0;
         dn_pos_q   <= '0;
         up_pulse_q <= '0;
         dn_pulse_q <= '0;
         aux1_q     <= '0;
         aux2_q     <= '0;
         lock_q     <= '0;
      end else begin
         idx_q      <= cursor_index;
         act_q      <= act_e'(cursor_action);
         act_qq     <= act_q;
         tog_q      <= tog_d;
         up_pos_q   <= up_pos_d;
         dn_pos_q   <= dn_pos_d;
         up_pulse_q <= up_pulse_d;
         dn_pulse_q <= dn_pulse_d;
         aux1_q     <= aux1_d;
         aux2_q     <= aux2_d;
         lock_q     <= lock_d;
      end
   end

   assign toggles      = tog_q;
   assign cmd_up_pos   = up_pos_q;
   assign cmd_dn_pos   = dn_pos_q;
   assign cmd_up_pulse = up_pulse_q;
   assign cmd_dn_pulse = dn_pulse_q;
   assign aux1_pos     = aux1_q;
   assign aux2_pos     = aux2_q;

endmodule

// File: tb/tb_panel_switch_bank.sv
// Directed bench for panel_switch_bank: hand-computed expectations for toggles,
// momentary positions/pulses with lockout, AUX latching and reset.
module tb_panel_switch_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  cursor_index;
   logic [1:0]  cursor_action;
   logic [17:0] toggles;
   logic [4:0]  cmd_up_pos, cmd_dn_pos, cmd_up_pulse, cmd_dn_pulse;
   logic [1:0]  aux1_pos, aux2_pos;

   int unsigned total = 0;
   int unsigned bad   = 0;

   panel_switch_bank #(
      .SWITCHES_ST_COUNT      (18),
      .SWITCHES_ST_AUX1_INDEX (23),
      .SWITCHES_ST_AUX2_INDEX (24),
      .LOCKOUT_CYCLES         (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cursor_index  (cursor_index),
      .cursor_action (cursor_action),
      .toggles       (toggles),
      .cmd_up_pos    (cmd_up_pos),
      .cmd_dn_pos    (cmd_dn_pos),
      .cmd_up_pulse  (cmd_up_pulse),
      .cmd_dn_pulse  (cmd_dn_pulse),
      .aux1_pos      (aux1_pos),
      .aux2_pos      (aux2_pos)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle just past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] idx, input logic [1:0] act);
      cursor_index  = idx;
      cursor_action = act;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tog"},  32'(toggles),      32'h0);
      chk({tag, "_upp"},  32'(cmd_up_pos),   32'h0);
      chk({tag, "_dnp"},  32'(cmd_dn_pos),   32'h0);
      chk({tag, "_upl"},  32'(cmd_up_pulse), 32'h0);
      chk({tag, "_dnl"},  32'(cmd_dn_pulse), 32'h0);
      chk({tag, "_aux1"}, 32'(aux1_pos),     32'h0);
      chk({tag, "_aux2"}, 32'(aux2_pos),     32'h0);
   endtask

   initial begin
      reset = 1'b1;
      drive(5'd0, 2'd0);
      tick(3);
      reset = 1'b0;
      tick(1);
      chk_all_zero("rst");

      // toggles: one-cycle pipeline plus registered output
      drive(5'd5, 2'd1);
      tick(1);
      chk("tog_lat", 32'(toggles), 32'h0);
      tick(1);
      chk("tog5_set", 32'(toggles), 32'h00020);
      drive(5'd5, 2'd0);
      tick(2);
      chk("tog5_clr", 32'(toggles), 32'h0);
      drive(5'd3, 2'd2);
      tick(2);
      chk("tog3_act2", 32'(toggles), 32'h0);
      drive(5'd3, 2'd3);
      tick(2);
      drive(5'd17, 2'd1);
      tick(2);
      chk("tog17_set", 32'(toggles), 32'h20000);

      // momentary up on index 20
      drive(5'd20, 2'd3);
      tick(2);
      drive(5'd20, 2'd1);
      tick(2);
      chk("up20_pulse", 32'(cmd_up_pulse), 32'h04);
      chk("up20_pos",   32'(cmd_up_pos),   32'h04);
      chk("up20_dnl",   32'(cmd_dn_pulse), 32'h00);
      tick(1);
      chk("up20_pulse_end", 32'(cmd_up_pulse), 32'h00);
      chk("up20_pos_hold",  32'(cmd_up_pos),   32'h04);
      drive(5'd20, 2'd0);
      tick(2);
      chk("up20_rel_pos",   32'(cmd_up_pos),   32'h00);
      chk("up20_rel_pulse", 32'(cmd_up_pulse), 32'h00);

      // momentary down on 21, then lockout behaviour
      tick(20);
      drive(5'd21, 2'd2);
      tick(2);
      chk("dn21_pulse", 32'(cmd_dn_pulse), 32'h08);
      chk("dn21_pos",   32'(cmd_dn_pos),   32'h08);
      tick(1);
      chk("dn21_pulse_end", 32'(cmd_dn_pulse), 32'h00);
      drive(5'd21, 2'd0);
      tick(2);
      chk("dn21_rel_pos", 32'(cmd_dn_pos), 32'h00);
      drive(5'd21, 2'd2);
      tick(2);
      chk("lock_dn_pos",   32'(cmd_dn_pos),   32'h08);
      chk("lock_dn_pulse", 32'(cmd_dn_pulse), 32'h00);
      tick(1);
      chk("lock_dn_late",  32'(cmd_dn_pulse), 32'h00);
      drive(5'd21, 2'd1);
      tick(2);
      chk("lock_2to1_up",    32'(cmd_up_pos),   32'h08);
      chk("lock_2to1_dn",    32'(cmd_dn_pos),   32'h00);
      chk("lock_2to1_pulse", 32'(cmd_up_pulse), 32'h00);
      tick(20);
      drive(5'd21, 2'd2);
      tick(2);
      chk("unlock_1to2_pulse", 32'(cmd_dn_pulse), 32'h08);
      chk("unlock_1to2_up",    32'(cmd_up_pulse), 32'h00);
      chk("unlock_1to2_pos",   32'(cmd_dn_pos),   32'h08);
      tick(1);

      // AUX switches; moving away clears momentary positions
      drive(5'd23, 2'd3);
      tick(2);
      chk("move_clr_dn", 32'(cmd_dn_pos), 32'h00);
      chk("move_clr_up", 32'(cmd_up_pos), 32'h00);
      drive(5'd23, 2'd1);
      tick(2);
      chk("aux1_up", 32'(aux1_pos), 32'd1);
      drive(5'd23, 2'd3);
      tick(2);
      chk("aux1_hold", 32'(aux1_pos), 32'd1);
      drive(5'd24, 2'd2);
      tick(2);
      chk("aux2_dn", 32'(aux2_pos), 32'd2);
      drive(5'd23, 2'd0);
      tick(2);
      chk("aux1_ctr", 32'(aux1_pos), 32'd0);
      chk("aux2_keep", 32'(aux2_pos), 32'd2);

      // out-of-range index
      drive(5'd27, 2'd1);
      tick(2);
      chk("idx27_tog",  32'(toggles),    32'h20000);
      chk("idx27_aux1", 32'(aux1_pos),   32'd0);
      chk("idx27_upp",  32'(cmd_up_pos), 32'h00);

      // fill every toggle, aux1 down, then reset while a pulse is high
      drive(5'd0, 2'd3);
      tick(1);
      for (int i = 0; i < 18; i++) begin
         drive(5'(i), 2'd1);
         tick(1);
         drive(5'(i), 2'd3);
         tick(1);
      end
      tick(2);
      chk("tog_all", 32'(toggles), 32'h3FFFF);
      drive(5'd23, 2'd2);
      tick(2);
      chk("aux1_dn", 32'(aux1_pos), 32'd2);
      drive(5'd18, 2'd3);
      tick(2);
      drive(5'd18, 2'd1);
      tick(2);
      chk("pre_rst_pulse", 32'(cmd_up_pulse), 32'h01);
      reset = 1'b1;
      drive(5'd0, 2'd0);
      tick(1);
      chk_all_zero("midrst");
      reset = 1'b0;
      tick(3);
      chk_all_zero("postrst");

      // lockout counter must have been cleared by reset
      drive(5'd19, 2'd3);
      tick(2);
      drive(5'd19, 2'd2);
      tick(2);
      chk("postrst_pulse", 32'(cmd_dn_pulse), 32'h02);
      chk("postrst_pos",   32'(cmd_dn_pos),   32'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
